// File: rtl/fp_key_debouncer_if.sv
// ---------------------------------------------------------------------------
// fp_key_debouncer_if
// Bundles the front-panel key conditioner's data signals.
//   key_raw      8  raw, bouncing button lines (asynchronous to the clock)
//   clr_latch    1  single-cycle request to clear the sticky press flags
//   keys         8  debounced key state, 1 = pressed
//   press_latch  8  sticky per-key press flags
//   key_change   1  single-cycle pulse after any keys bit changed
// master: the environment (drives raw lines and clear, observes outputs)
// slave : the debouncer itself
// ---------------------------------------------------------------------------
interface fp_key_debouncer_if;
  logic [7:0] key_raw;
  logic       clr_latch;
  logic [7:0] keys;
  logic [7:0] press_latch;
  logic       key_change;

  modport master (
    output key_raw,
    output clr_latch,
    input  keys,
    input  press_latch,
    input  key_change
  );

  modport slave (
    input  key_raw,
    input  clr_latch,
    output keys,
    output press_latch,
    output key_change
  );
endinterface

// File: rtl/fp_key_debouncer.sv
// ---------------------------------------------------------------------------
// fp_key_debouncer
// Front-panel key conditioner feeding the SPI slave's 8-bit input port.
// Synchronises eight raw push-button lines, debounces each one on a
// prescaled sample tick, and keeps sticky press flags so that short presses
// between two SPI polls are not lost.
// Ports:
//   i_clk   system clock
//   i_nrst  asynchronous active-low reset
//   bus     fp_key_debouncer_if.slave (key_raw, clr_latch in;
//           keys, press_latch, key_change out)
// Parameters:
//   PRESCALE      clock cycles per sample tick (>= 1)
//   DEBOUNCE_CNT  consecutive differing ticks needed to accept a change (>= 1)
//   ACTIVE_LOW    1: raw low = pressed, 0: raw high = pressed
// ---------------------------------------------------------------------------
module fp_key_debouncer #(
  parameter int PRESCALE     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  fp_key_debouncer_if.slave bus
);

  // Prescaler width is at least one bit so PRESCALE == 1 still elaborates.
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ONE   = PS_W'(1);
  localparam logic [PS_W-1:0]  PS_ZERO  = {PS_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Level of a released line; also the XOR mask that turns a synchronised
  // sample into "1 = pressed".
  localparam logic [7:0] IDLE_LVL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [7:0]       r_sync1;
  logic [7:0]       r_sync2;
  logic [PS_W-1:0]  r_ps;
  logic [7:0]       r_keys;
  logic [7:0]       r_keys_d;
  logic [CNT_W-1:0] r_cnt [8];
  logic [7:0]       r_latch;
  logic             r_key_change;

  logic             w_tick;
  logic [7:0]       w_norm;
  logic [7:0]       w_keys_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [8];
  logic [7:0]       w_rise;
  logic [7:0]       w_latch_nxt;

  // Two-flop synchroniser; reset to the released level so nothing looks pressed.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_sync1 <= IDLE_LVL;
      r_sync2 <= IDLE_LVL;
    end else begin
      r_sync1 <= bus.key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_norm = r_sync2 ^ IDLE_LVL;

  // Sample-tick prescaler: counts 0..PRESCALE-1 and wraps on the tick cycle.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_ps <= PS_ZERO;
    end else if (w_tick) begin
      r_ps <= PS_ZERO;
    end else begin
      r_ps <= r_ps + PS_ONE;
    end
  end

  assign w_tick = (r_ps == PS_LAST);

  // Per-bit debounce decision. A tick that agrees with the current key state
  // restarts the run, so a single matching sample rejects a bounce.
  always_comb begin
    w_keys_nxt = r_keys;
    for (int i = 0; i < 8; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_tick) begin
        if (w_norm[i] == r_keys[i]) begin
          w_cnt_nxt[i] = CNT_ZERO;
        end else if (r_cnt[i] == CNT_LAST) begin
          w_keys_nxt[i] = ~r_keys[i];
          w_cnt_nxt[i]  = CNT_ZERO;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // Debounced key state and per-bit run counters.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_keys <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      r_keys <= w_keys_nxt;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Change pulse: compare the key state with its one-cycle-old copy, which
  // yields a single pulse the cycle after an update however many bits moved.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_keys_d     <= 8'h00;
      r_key_change <= 1'b0;
    end else begin
      r_keys_d     <= r_keys;
      r_key_change <= (r_keys != r_keys_d);
    end
  end

  // Sticky press flags: a rising key sets its flag in the same cycle; when a
  // clear coincides with a rise the set wins because it is ORed after the clear.
  always_comb begin
    w_rise = w_keys_nxt & ~r_keys;
    if (bus.clr_latch) begin
      w_latch_nxt = w_rise;
    end else begin
      w_latch_nxt = r_latch | w_rise;
    end
  end

  // Press-latch register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_latch <= 8'h00;
    end else begin
      r_latch <= w_latch_nxt;
    end
  end

  assign bus.keys        = r_keys;
  assign bus.press_latch = r_latch;
  assign bus.key_change  = r_key_change;

endmodule

// File: tb/tb_fp_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_fp_key_debouncer
// Bench for fp_key_debouncer with PRESCALE=4, DEBOUNCE_CNT=3, ACTIVE_LOW=1.
// A behavioural model tracks, per key, the history of tick samples since the
// key last changed; a key flips once its newest DEBOUNCE_CNT samples all
// disagree with it. Directed scenarios pin the model with literal values,
// then randomised bouncing stimulus runs against the model.
// ---------------------------------------------------------------------------
module tb_fp_key_debouncer;

  localparam int PRESCALE = 4;
  localparam int DEB      = 3;

  logic clk = 1'b0;
  logic nrst;

  fp_key_debouncer_if bus ();

  fp_key_debouncer #(
    .PRESCALE    (PRESCALE),
    .DEBOUNCE_CNT(DEB),
    .ACTIVE_LOW  (1)
  ) dut (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int kc_seen = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [7:0] m_keys, m_latch, m_s1, m_s2;
  logic       m_kc, m_chg;
  int         m_cyc;
  bit         m_hist [8][$];

  // Model: one step per clock edge, reset follows the asynchronous reset line.
  always @(posedge clk or negedge nrst) begin : model
    logic [7:0] norm, nk;
    bit tick, all_diff;
    if (!nrst) begin
      m_keys = 8'h00; m_latch = 8'h00; m_kc = 1'b0; m_chg = 1'b0;
      m_s1 = 8'hFF; m_s2 = 8'hFF; m_cyc = 0;
      for (int i = 0; i < 8; i++) m_hist[i].delete();
    end else begin
      norm = ~m_s2;
      tick = ((m_cyc % PRESCALE) == PRESCALE - 1);
      nk = m_keys;
      if (tick) begin
        for (int i = 0; i < 8; i++) begin
          m_hist[i].push_back(norm[i]);
          if (m_hist[i].size() > 8) void'(m_hist[i].pop_front());
          all_diff = (m_hist[i].size() >= DEB);
          for (int k = 0; k < DEB && k < m_hist[i].size(); k++)
            if (m_hist[i][m_hist[i].size() - 1 - k] == m_keys[i]) all_diff = 1'b0;
          if (all_diff) begin
            nk[i] = ~m_keys[i];
            m_hist[i].delete();
          end
        end
      end
      m_kc    = m_chg;
      m_chg   = (nk != m_keys);
      m_latch = (bus.clr_latch ? 8'h00 : m_latch) | (nk & ~m_keys);
      m_keys  = nk;
      m_s2    = m_s1;
      m_s1    = bus.key_raw;
      m_cyc++;
    end
  end

  // Compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    chk("keys_vs_model", bus.keys, m_keys);
    chk("latch_vs_model", bus.press_latch, m_latch);
    chk("kc_vs_model", {7'b0000000, bus.key_change}, {7'b0000000, m_kc});
    if (bus.key_change === 1'b1) kc_seen++;
  end

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  int kc_mark;
  int hold;
  logic [7:0] target;

  initial begin
    nrst = 1'b0;
    bus.key_raw = 8'hFF;
    bus.clr_latch = 1'b0;

    // 1: reset with all keys released, then idle
    wait_edges(3);
    chk("t1_keys_in_reset", bus.keys, 8'h00);
    nrst = 1'b1;
    wait_edges(20);
    chk("t1_keys", bus.keys, 8'h00);
    chk("t1_latch", bus.press_latch, 8'h00);
    chk("t1_no_pulse", 8'(kc_seen), 8'h00);

    // 2: press key 0 before edge 21 -> sync by 22, ticks 24/28/32
    bus.key_raw = 8'hFE;
    wait_edges(11);
    chk("t2_keys_before", bus.keys, 8'h00);
    wait_edges(1);
    chk("t2_keys_after", bus.keys, 8'h01);
    chk("t2_kc_not_yet", {7'b0000000, bus.key_change}, 8'h00);
    wait_edges(1);
    chk("t2_kc_pulse", {7'b0000000, bus.key_change}, 8'h01);
    chk("t2_latch", bus.press_latch, 8'h01);

    // 3: bounce on key 3: low 2 ticks, high 1, low 2
    kc_mark = kc_seen;
    bus.key_raw = 8'hF6; wait_edges(8);
    bus.key_raw = 8'hFE; wait_edges(4);
    bus.key_raw = 8'hF6; wait_edges(8);
    bus.key_raw = 8'hFE; wait_edges(20);
    chk("t3_keys", bus.keys, 8'h01);
    chk("t3_no_pulse", 8'(kc_seen - kc_mark), 8'h00);

    // 4: clear latch, then apply 0F at once
    bus.clr_latch = 1'b1; wait_edges(1); bus.clr_latch = 1'b0;
    chk("t4_latch_cleared", bus.press_latch, 8'h00);
    kc_mark = kc_seen;
    bus.key_raw = 8'h0F;
    wait_edges(24);
    chk("t4_keys", bus.keys, 8'hF0);
    chk("t4_latch", bus.press_latch, 8'hF0);
    chk("t4_one_pulse", 8'(kc_seen - kc_mark), 8'h01);

    // 5: fresh reset, key 0 pressed from release; key 1 rises on edge 24
    nrst = 1'b0; bus.key_raw = 8'hFE;
    wait_edges(2);
    nrst = 1'b1;
    wait_edges(12);
    chk("t5_keys0", bus.keys, 8'h01);
    chk("t5_latch0", bus.press_latch, 8'h01);
    bus.key_raw = 8'hFC;
    wait_edges(11);
    bus.clr_latch = 1'b1;
    wait_edges(1);
    bus.clr_latch = 1'b0;
    chk("t5_keys1", bus.keys, 8'h03);
    chk("t5_set_wins", bus.press_latch, 8'h02);

    // 6: key 2 two ticks into debounce (ticks 28, 32) when reset drops
    bus.key_raw = 8'hF8;
    wait_edges(9);
    nrst = 1'b0;
    #1;
    chk("t6_keys_async", bus.keys, 8'h00);
    chk("t6_latch_async", bus.press_latch, 8'h00);
    wait_edges(3);
    kc_mark = kc_seen;
    nrst = 1'b1;
    wait_edges(11);
    chk("t6_keys_before", bus.keys, 8'h00);
    chk("t6_no_pulse", 8'(kc_seen - kc_mark), 8'h00);
    wait_edges(1);
    chk("t6_keys_full", bus.keys, 8'h07);
    wait_edges(1);
    chk("t6_kc_pulse", {7'b0000000, bus.key_change}, 8'h01);

    // Randomised bouncing stimulus against the model
    target = 8'hFF;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) target = 8'($urandom);
      hold = $urandom_range(1, 6);
      bus.key_raw = target ^ (($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00);
      wait_edges(hold);
      bus.key_raw = target;
      if ($urandom_range(0, 7) == 0) bus.clr_latch = 1'b1;
      wait_edges(1);
      bus.clr_latch = 1'b0;
      wait_edges($urandom_range(3, 20));
      if ($urandom_range(0, 59) == 0) begin
        nrst = 1'b0;
        wait_edges($urandom_range(1, 3));
        nrst = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
